// File: rtl/input_debounce_sync.sv
// rtl/input_debounce_sync.sv - synchroniser plus counter-qualified debounce FSM with rise/fall strobes
// Optional sticky rising-edge flag enabled by defining DEBOUNCE_EDGE_CAPTURE_EN.
module input_debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16,
    parameter int INVERT          = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    input  logic enable,
    output logic btn_clean,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic edge_capture,
    input  logic edge_clear
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   w_sync_q;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nx;
    logic                   r_btn;
    logic                   w_btn_nx;
    logic                   r_rise_pulse;
    logic                   w_rise_nx;
    logic                   r_fall_pulse;
    logic                   w_fall_nx;

    // Active-low sources are flipped before synchronising so the FSM always sees "1 = pressed".
    assign w_s      = (INVERT != 0) ? ~raw_in : raw_in;
    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // Synchroniser shift chain; keeps shifting regardless of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_s};
        end
    end

    // Next-state logic: a new level is accepted only after DEBOUNCE_CYCLES consecutive qualified samples.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_btn_nx   = r_btn;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                if (enable && w_sync_q) begin
                    w_state_nx = WAIT_HIGH;
                    w_cnt_nx   = LP_CNT_ONE;
                end else begin
                    w_cnt_nx   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!enable || !w_sync_q) begin
                    w_state_nx = IDLE_LOW;
                    w_cnt_nx   = '0;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nx = IDLE_HIGH;
                    w_cnt_nx   = '0;
                    w_btn_nx   = 1'b1;
                    w_rise_nx  = 1'b1;
                end else begin
                    w_cnt_nx   = r_cnt + LP_CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (enable && !w_sync_q) begin
                    w_state_nx = WAIT_LOW;
                    w_cnt_nx   = LP_CNT_ONE;
                end else begin
                    w_cnt_nx   = '0;
                end
            end
            WAIT_LOW: begin
                if (!enable || w_sync_q) begin
                    w_state_nx = IDLE_HIGH;
                    w_cnt_nx   = '0;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nx = IDLE_LOW;
                    w_cnt_nx   = '0;
                    w_btn_nx   = 1'b0;
                    w_fall_nx  = 1'b1;
                end else begin
                    w_cnt_nx   = r_cnt + LP_CNT_ONE;
                end
            end
            default: begin
                w_state_nx = IDLE_LOW;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // State, counter, level and strobe registers; reset mid-qualification drops the count silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE_LOW;
            r_cnt        <= '0;
            r_btn        <= 1'b0;
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_btn        <= w_btn_nx;
            r_rise_pulse <= w_rise_nx;
            r_fall_pulse <= w_fall_nx;
        end
    end

    assign btn_clean  = r_btn;
    assign rise_pulse = r_rise_pulse;
    assign fall_pulse = r_fall_pulse;

`ifdef DEBOUNCE_EDGE_CAPTURE_EN
    logic r_edge_capture;

    // Sticky press flag: a rise strobe sets it and beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_capture <= 1'b0;
        end else if (r_rise_pulse) begin
            r_edge_capture <= 1'b1;
        end else if (edge_clear) begin
            r_edge_capture <= 1'b0;
        end
    end

    assign edge_capture = r_edge_capture;
`else
    logic w_unused_edge_clear;

    assign w_unused_edge_clear = edge_clear;
    assign edge_capture        = 1'b0;
`endif

endmodule
